// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction-fetch stage with the IF/ID pipeline register.
//            Holds the PC, drives the instruction-memory address, and latches
//            the fetched word, its PC and PC+4. Honours stall, flush and
//            redirect requests; flags misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misalign
);

  logic [31:0] pc;
  logic [31:0] pc_next_seq;

  // Sequential successor of the current PC; wraps modulo 2^32.
  always_comb begin
    pc_next_seq = pc + 32'd4;
  end

  // PC and IF/ID register update: rst > redirect > flush > stall > advance.
  // A bubble only replaces instr/valid; the pc fields keep their old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 32'd0;
      if_id_pc_plus4 <= 32'd4;
      if_id_valid    <= 1'b0;
    end else if (redirect_valid) begin
      // The low bits are dropped so imem_addr stays word aligned.
      pc          <= {redirect_pc[31:2], 2'b00};
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if (!stall) begin
        pc <= pc_next_seq;
      end
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc             <= pc_next_seq;
      if_id_instr    <= imem_rdata;
      if_id_pc       <= pc;
      if_id_pc_plus4 <= pc_next_seq;
      if_id_valid    <= 1'b1;
    end
  end

  // Sticky misaligned-target flag; cleared only by reset, never blocks fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end

  // The memory address is the PC register itself; the opcode is a pure slice.
  always_comb begin
    imem_addr    = pc;
    if_id_opcode = if_id_instr[6:0];
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the RV32I 5-stage CPU. It holds the PC, drives the instruction-memory address, and latches the fetched word, its PC and PC+4 into the IF/ID register. `if_id_opcode` feeds `type_decoder.opcode` directly in the decode stage. It honours stall requests from hazard detection and redirect/flush requests from branch/jump resolution.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): word inserted as a bubble.

**Ports**
- `clk`  in  1: the single clock; everything is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold the PC and the IF/ID register (load-use hazard).
- `flush`  in  1: replace the IF/ID contents with a bubble.
- `redirect_valid`  in  1: a taken branch or jump has been resolved.
- `redirect_pc`  in  32: target address for a redirect.
- `imem_addr`  out  32: instruction-memory address; equals the PC register.
- `imem_rdata`  in  32: instruction word. It is combinational: valid in the same cycle as `imem_addr`.
- `if_id_instr`  out  32: latched instruction.
- `if_id_opcode`  out  7: `if_id_instr[6:0]`, goes to the type decoder.
- `if_id_pc`  out  32: PC of the latched instruction.
- `if_id_pc_plus4`  out  32: `if_id_pc + 4`, modulo 2^32.
- `if_id_valid`  out  1: 1 when the IF/ID register holds a real fetched instruction, 0 for a bubble.
- `misalign`  out  1: sticky error flag; set when a redirect target has `[1:0] != 0`.

## Operation

- **Registers.** The block holds `pc` (32 bits), the IF/ID register {instr, pc, pc_plus4, valid}, and the `misalign` flag.
- **Update priority each edge:** `rst` > `redirect_valid` > `flush` > `stall` > normal advance.
  - **rst:** `pc` <= `RESET_PC`. IF/ID <= {`NOP_INSTR`, 0, 4, valid=0}. `misalign` <= 0.
  - **redirect_valid:**
    - `pc` <= {`redirect_pc[31:2]`, 2'b00}.
    - IF/ID <= bubble, even if `stall` is high. A redirect is never lost.
    - If `redirect_pc[1:0] != 0`, set `misalign`.
  - **flush, no redirect:** IF/ID <= bubble. `pc` holds if `stall` is high, otherwise `pc` <= `pc` + 4.
  - **stall only:** `pc` and IF/ID hold their values.
  - **normal:** `pc` <= `pc` + 4. IF/ID <= {`imem_rdata`, `pc`, `pc` + 4, valid=1}.
- **Bubble definition:** instr = `NOP_INSTR`, valid = 0. The pc and pc_plus4 fields hold their previous values.
- **Arithmetic:** all PC arithmetic is 32-bit unsigned and wraps, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- **Addressing:** `imem_addr` always equals `pc`, and `pc[1:0]` is always 2'b00.
- **Opcode output:** `if_id_opcode` is a pure slice of `if_id_instr`. Under a bubble it reads 7'h13, which decodes as `i_type_addi`. Downstream control must qualify it with `if_id_valid`.
- **misalign:** stays set until `rst`. It does not block fetch.

## Timing

- **Fetch latency:** 1 cycle. The word at `imem_addr` in cycle N appears on `if_id_*` after edge N+1.
- **After reset deasserts:** in the first cycle `imem_addr` = `RESET_PC` and `if_id_valid` = 0. After the next edge `if_id_valid` = 1 and `if_id_pc` = `RESET_PC`.
- **Redirect:** with `redirect_valid` high in cycle N:
  - in cycle N+1, `imem_addr` = target and `if_id_valid` = 0;
  - in cycle N+2, `if_id_pc` = target with `if_id_valid` = 1.
- **Stall:** a stall held for K cycles freezes all outputs for K cycles. There is no loss or duplication of instructions.
- **Reset mid-stream:** reset overrides any pending stall, flush or redirect in the same cycle.
- **Output timing:** every output except `imem_addr` is registered. `imem_addr` is also registered, since it is the PC register itself.

## Test plan

1. **Reset then run.** Assert `rst` for 2 cycles, then let memory return `mem[a] = a`.
   - Expect `if_id_valid` = 0, `if_id_opcode` = 7'h13 during reset.
   - Then `if_id_pc` = 0, 4, 8 on successive cycles, with `if_id_instr` = `if_id_pc`.
2. **Opcode sweep.** Memory returns 0x33, 0x03, 0x13, 0x67, 0x23, 0x63, 0x17, 0x37, 0x6F at addresses 0 to 0x20.
   - Expect `if_id_opcode` to show each value, one per cycle, 1 cycle after its address was on `imem_addr`.
3. **Stall.** Raise `stall` for 3 cycles while `pc` = 0x10.
   - Expect `imem_addr` to hold 0x10 and `if_id_pc` to hold 0x0C for 3 cycles.
   - After release, expect 0x10 and then 0x14 with no gap.
4. **Redirect.** Assert `redirect_valid` with `redirect_pc` = 0x100 together with `stall` = 1.
   - Next cycle: `imem_addr` = 0x100, `if_id_valid` = 0.
   - Following cycle: `if_id_pc` = 0x100, valid = 1.
5. **Flush, then stall+flush.**
   - `flush` alone at `pc` = 0x20: expect IF/ID bubble and `pc` = 0x24.
   - `flush` with `stall`: expect a bubble and `pc` held.
6. **Wrap and misalign.**
   - Redirect to 0xFFFF_FFFC: expect the next `pc` = 0x0 and `if_id_pc_plus4` = 0x0.
   - Redirect to 0x202: expect `pc` = 0x200 and `misalign` = 1, which persists until `rst`.
